// File: rtl/microseq_store.sv
// Patchable clocked control store with integrated micro-sequencer: holds uPC,
// picks the next micro-address, and registers the control word for it.
module microseq_store #(
  parameter int unsigned WORD_W     = 34,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DEPTH      = 50,
  parameter int unsigned FETCH_ADDR = 0,
  parameter logic [WORD_W*DEPTH-1:0] INIT_VEC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [1:0]        seq_op,
  input  logic              cond,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [ADDR_W-1:0] dispatch_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              err_clr,
  output logic [WORD_W-1:0] ctrl_out,
  output logic [ADDR_W-1:0] upc,
  output logic              err
);

  localparam int unsigned EXT_W = ADDR_W + 1;
  localparam logic [EXT_W-1:0]  DEPTH_EXT  = EXT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] FETCH_A    = ADDR_W'(FETCH_ADDR);
  localparam logic [WORD_W-1:0] FETCH_WORD = INIT_VEC[WORD_W*(DEPTH-FETCH_ADDR)-1 -: WORD_W];

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_CJMP = 2'b01;
  localparam logic [1:0] OP_DISP = 2'b10;

  logic [WORD_W-1:0] mem      [DEPTH];
  logic [WORD_W-1:0] init_mem [DEPTH];
  logic [EXT_W-1:0]  nxt_ext;
  logic [ADDR_W-1:0] nxt;
  logic              seq_err;
  logic              wr_err;
  logic [WORD_W-1:0] rd_word;

  // Slice the ROM image; word 0 sits in the most significant bits.
  for (genvar g = 0; g < DEPTH; g++) begin : g_init
    assign init_mem[g] = INIT_VEC[WORD_W*(DEPTH-g)-1 -: WORD_W];
  end

  // Next-address select, computed one bit wider so ADDR_W overflow is caught.
  always_comb begin
    nxt_ext = '0;
    case (seq_op)
      OP_INC:  nxt_ext = {1'b0, upc} + EXT_W'(1);
      OP_CJMP: nxt_ext = cond ? {1'b0, jump_addr} : {1'b0, upc} + EXT_W'(1);
      OP_DISP: nxt_ext = {1'b0, dispatch_addr};
      default: nxt_ext = {1'b0, FETCH_A};
    endcase
    seq_err = (nxt_ext >= DEPTH_EXT);
    nxt     = seq_err ? FETCH_A : nxt_ext[ADDR_W-1:0];
    wr_err  = wr_en && ({1'b0, wr_addr} >= DEPTH_EXT);
  end

  // Read mux over implemented words only; nxt is always in range here.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (nxt == ADDR_W'(i)) rd_word = mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_mem[i];
      upc      <= FETCH_A;
      ctrl_out <= FETCH_WORD;
      err      <= 1'b0;
    end else begin
      // rd_word samples the pre-write array, so same-edge reads see the old word.
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (wr_addr == ADDR_W'(i))) mem[i] <= wr_data;
      end
      if (!stall) begin
        upc      <= nxt;
        ctrl_out <= rd_word;
        if (seq_err || wr_err) err <= 1'b1;
        else if (err_clr)      err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_microseq_store.sv
// Directed, table-driven self-checking bench for microseq_store
// (DEPTH=8, WORD_W=8, ADDR_W=4, ROM word i = 8'h10+i).
module tb_microseq_store;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 8;
  localparam logic [WORD_W*DEPTH-1:0] ROM = 64'h1011_1213_1415_1617;

  logic              clk = 1'b0;
  logic              reset, stall, cond, wr_en, err_clr;
  logic [1:0]        seq_op;
  logic [ADDR_W-1:0] jump_addr, dispatch_addr, wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic [WORD_W-1:0] ctrl_out;
  logic [ADDR_W-1:0] upc;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  microseq_store #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .FETCH_ADDR(0), .INIT_VEC(ROM)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .seq_op(seq_op), .cond(cond),
    .jump_addr(jump_addr), .dispatch_addr(dispatch_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .err_clr(err_clr),
    .ctrl_out(ctrl_out), .upc(upc), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, stl;
    logic [1:0] op;
    logic       cnd;
    logic [3:0] ja, da;
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       ec;
    logic [3:0] e_upc;
    logic [7:0] e_ctrl;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic rst, input logic stl, input logic [1:0] op, input logic cnd,
                   input logic [3:0] ja, input logic [3:0] da, input logic we,
                   input logic [3:0] wa, input logic [7:0] wd, input logic ec,
                   input logic [3:0] eu, input logic [7:0] ecw, input logic ee);
    vec_t t;
    t.rst = rst; t.stl = stl; t.op = op; t.cnd = cnd; t.ja = ja; t.da = da;
    t.we = we; t.wa = wa; t.wd = wd; t.ec = ec;
    t.e_upc = eu; t.e_ctrl = ecw; t.e_err = ee;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, step past the rising edge, then compare.
  task automatic apply(input int idx, input vec_t t);
    reset = t.rst; stall = t.stl; seq_op = t.op; cond = t.cnd;
    jump_addr = t.ja; dispatch_addr = t.da; wr_en = t.we; wr_addr = t.wa;
    wr_data = t.wd; err_clr = t.ec;
    @(posedge clk);
    #1;
    chk("upc",      idx, 32'(upc),      32'(t.e_upc));
    chk("ctrl_out", idx, 32'(ctrl_out), 32'(t.e_ctrl));
    chk("err",      idx, 32'(err),      32'(t.e_err));
  endtask

  localparam logic [1:0] INC = 2'b00, CJ = 2'b01, DS = 2'b10, FE = 2'b11;

  initial begin
    vec_t t;
    reset = 1'b1; stall = 1'b0; seq_op = INC; cond = 1'b0; jump_addr = '0;
    dispatch_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; err_clr = 1'b0;

    //  rst stl op   c  ja    da    we wa    wd     ec   upc   ctrl   err
    v(1, 0, INC, 0, 4'd0, 4'd0, 0, 4'd0, 8'h00, 0,  4'd0, 8'h10, 0);
    v(0, 0, INC, 0, 4'd0, 4'd0, 0, 4'd0, 8'h00, 0,  4'd1, 8'h11, 0);
    v(0, 0, INC, 0, 4'd0, 4'd0, 0, 4'd0, 8'h00, 0,  4'd2, 8'h12, 0);
    v(0, 0, INC, 0, 4'd0, 4'd0, 0, 4'd0, 8'h00, 0,  4'd3, 8'h13, 0);
    v(0, 0, CJ,  0, 4'd6, 4'd0, 0, 4'd0, 8'h00, 0,  4'd4, 8'h14, 0);
    v(0, 0, CJ,  1, 4'd6, 4'd0, 0, 4'd0, 8'h00, 0,  4'd6, 8'h16, 0);
    v(0, 0, DS,  0, 4'd0, 4'd2, 0, 4'd0, 8'h00, 0,  4'd2, 8'h12, 0);
    v(0, 0, DS,  0, 4'd0, 4'd7, 0, 4'd0, 8'h00, 0,  4'd7, 8'h17, 0);
    v(0, 0, INC, 0, 4'd0, 4'd0, 0, 4'd0, 8'h00, 0,  4'd0, 8'h10, 1);
    v(0, 0, INC, 0, 4'd0, 4'd0, 0, 4'd0, 8'h00, 1,  4'd1, 8'h11, 0);
    v(0, 0, CJ,  1, 4'd9, 4'd0, 0, 4'd0, 8'h00, 0,  4'd0, 8'h10, 1);
    v(0, 0, INC, 0, 4'd0, 4'd0, 0, 4'd0, 8'h00, 1,  4'd1, 8'h11, 0);
    v(0, 0, DS,  0, 4'd0, 4'd4, 0, 4'd0, 8'h00, 0,  4'd4, 8'h14, 0);
    v(0, 0, INC, 0, 4'd0, 4'd0, 1, 4'd5, 8'hAA, 0,  4'd5, 8'h15, 0);
    v(0, 0, FE,  0, 4'd0, 4'd0, 0, 4'd0, 8'h00, 0,  4'd0, 8'h10, 0);
    v(0, 0, INC, 0, 4'd0, 4'd0, 0, 4'd0, 8'h00, 0,  4'd1, 8'h11, 0);
    v(0, 0, INC, 0, 4'd0, 4'd0, 0, 4'd0, 8'h00, 0,  4'd2, 8'h12, 0);
    v(0, 0, INC, 0, 4'd0, 4'd0, 0, 4'd0, 8'h00, 0,  4'd3, 8'h13, 0);
    v(0, 0, INC, 0, 4'd0, 4'd0, 0, 4'd0, 8'h00, 0,  4'd4, 8'h14, 0);
    v(0, 0, INC, 0, 4'd0, 4'd0, 0, 4'd0, 8'h00, 0,  4'd5, 8'hAA, 0);
    v(0, 1, DS,  1, 4'd0, 4'd7, 0, 4'd0, 8'h00, 0,  4'd5, 8'hAA, 0);
    v(0, 1, DS,  1, 4'd0, 4'd7, 1, 4'd5, 8'hBB, 0,  4'd5, 8'hAA, 0);
    v(0, 1, DS,  1, 4'd0, 4'd7, 0, 4'd0, 8'h00, 0,  4'd5, 8'hAA, 0);
    v(0, 0, DS,  0, 4'd0, 4'd7, 0, 4'd0, 8'h00, 0,  4'd7, 8'h17, 0);
    v(0, 0, DS,  0, 4'd0, 4'd5, 0, 4'd0, 8'h00, 0,  4'd5, 8'hBB, 0);
    v(0, 0, FE,  0, 4'd0, 4'd0, 1, 4'd9, 8'hCC, 0,  4'd0, 8'h10, 1);
    v(0, 0, DS,  0, 4'd0, 4'd8, 0, 4'd0, 8'h00, 1,  4'd0, 8'h10, 1);
    v(0, 0, INC, 0, 4'd0, 4'd0, 0, 4'd0, 8'h00, 1,  4'd1, 8'h11, 0);
    v(1, 0, DS,  0, 4'd0, 4'd3, 0, 4'd0, 8'h00, 0,  4'd0, 8'h10, 0);
    v(0, 0, DS,  0, 4'd0, 4'd5, 0, 4'd0, 8'h00, 0,  4'd5, 8'h15, 0);
    v(1, 1, INC, 0, 4'd0, 4'd0, 1, 4'd6, 8'hCC, 1,  4'd0, 8'h10, 0);
    v(0, 0, DS,  0, 4'd0, 4'd6, 0, 4'd0, 8'h00, 0,  4'd6, 8'h16, 0);
    v(0, 0, INC, 0, 4'd0, 4'd0, 0, 4'd0, 8'h00, 0,  4'd7, 8'h17, 0);
    v(0, 0, CJ,  0, 4'd2, 4'd0, 0, 4'd0, 8'h00, 0,  4'd0, 8'h10, 1);
    v(1, 0, INC, 0, 4'd0, 4'd0, 0, 4'd0, 8'h00, 0,  4'd0, 8'h10, 0);
    v(0, 0, DS,  0, 4'd0, 4'd15,0, 4'd0, 8'h00, 0,  4'd0, 8'h10, 1);
    v(0, 0, FE,  0, 4'd0, 4'd0, 0, 4'd0, 8'h00, 1,  4'd0, 8'h10, 0);

    foreach (vecs[i]) apply(i, vecs[i]);

    // Patch every word while stalled; the held word must not change even
    // when the current upc is rewritten.
    for (int i = 0; i < 8; i++) begin
      t = '{rst:0, stl:1, op:DS, cnd:0, ja:0, da:4'd3, we:1, wa:4'(i), wd:8'hA0 + 8'(i),
            ec:0, e_upc:0, e_ctrl:8'h10, e_err:0};
      apply(100 + i, t);
    end
    t = '{rst:0, stl:0, op:FE, cnd:0, ja:0, da:0, we:0, wa:0, wd:0,
          ec:0, e_upc:0, e_ctrl:8'hA0, e_err:0};
    apply(110, t);
    for (int i = 1; i < 8; i++) begin
      t = '{rst:0, stl:0, op:INC, cnd:0, ja:0, da:0, we:0, wa:0, wd:0,
            ec:0, e_upc:4'(i), e_ctrl:8'hA0 + 8'(i), e_err:0};
      apply(110 + i, t);
    end
    t = '{rst:0, stl:0, op:INC, cnd:0, ja:0, da:0, we:0, wa:0, wd:0,
          ec:0, e_upc:0, e_ctrl:8'hA0, e_err:1};
    apply(120, t);

    // Reset restores the whole ROM image.
    t = '{rst:1, stl:0, op:INC, cnd:0, ja:0, da:0, we:0, wa:0, wd:0,
          ec:0, e_upc:0, e_ctrl:8'h10, e_err:0};
    apply(130, t);
    for (int i = 1; i < 8; i++) begin
      t = '{rst:0, stl:0, op:INC, cnd:0, ja:0, da:0, we:0, wa:0, wd:0,
            ec:0, e_upc:4'(i), e_ctrl:8'h10 + 8'(i), e_err:0};
      apply(130 + i, t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/microseq_store.md
Name: microseq_store

Overview:
- Parametrised, patchable, clocked control store with an integrated micro-sequencer.
- Successor to the combinational state-indexed control ROM in the control unit.
- Holds the micro-program address register (uPC), computes the next micro-address, and presents a registered control word for the current uPC.
- Micro-words can be overwritten at run time through a write port; reset restores the ROM image.

Parameters:
- WORD_W, 34: control word width in bits.
- ADDR_W, 6: micro-address width.
- DEPTH, 50: number of implemented words. Must satisfy DEPTH <= 2**ADDR_W.
- FETCH_ADDR, 0: reset, fetch and recovery micro-address. Must be < DEPTH.
- INIT_VEC, all zeros, WORD_W*DEPTH bits: ROM image. Word 0 is the most significant WORD_W bits, i.e. first in the concatenation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- stall  in  1  hold uPC and ctrl_out.
- seq_op  in  2  next-address select: 00 INC, 01 CJMP, 10 DISPATCH, 11 FETCH.
- cond  in  1  condition for CJMP.
- jump_addr  in  ADDR_W  CJMP target.
- dispatch_addr  in  ADDR_W  DISPATCH target (opcode-decoded).
- wr_en  in  1  micro-word write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WORD_W  write data.
- err_clr  in  1  clears err.
- ctrl_out  out  WORD_W  control word at upc (registered).
- upc  out  ADDR_W  current micro-address.
- err  out  1  sticky addressing error.

Behaviour:
- Storage: DEPTH x WORD_W register array.
- Reset (synchronous, highest priority; overrides stall, wr_en, err_clr):
  - every word i is loaded from INIT_VEC word i;
  - upc = FETCH_ADDR;
  - ctrl_out = INIT_VEC word FETCH_ADDR;
  - err = 0.
- Next-address computation (combinational, from the current upc):
  - INC: upc+1.
  - CJMP: jump_addr if cond=1, else upc+1.
  - DISPATCH: dispatch_addr.
  - FETCH: FETCH_ADDR.
- Range check: if the computed address is >= DEPTH, including INC from DEPTH-1 and ADDR_W overflow, then next = FETCH_ADDR and err is set to 1 on that edge.
- Update (no reset, stall=0): upc <= next and ctrl_out <= mem[next], read before any same-edge write.
  - ctrl_out therefore always equals the word at upc; one cycle of latency from seq_op to ctrl_out.
- stall=1:
  - upc, ctrl_out and err hold;
  - seq_op, cond and targets are ignored;
  - writes still occur.
- Write: wr_en=1 with wr_addr < DEPTH writes mem[wr_addr] <= wr_data at the edge.
  - Write and read of the same word on the same edge: ctrl_out gets the OLD word; the new word is visible on the next read of that address.
  - A write to the current upc does not change the held ctrl_out.
  - wr_en=1 with wr_addr >= DEPTH: no array change; err set to 1.
- err is sticky. err_clr=1 clears it unless a new error occurs on the same edge; set wins.
- Unimplemented or out-of-range words are never output; ctrl_out is never X after reset.

Test Plan:
All scenarios use DEPTH=8, WORD_W=8, ADDR_W=4, FETCH_ADDR=0, INIT_VEC word i = 8'h10+i.
1. Reset for 1 cycle, then seq_op=INC for 3 cycles -> upc 0,1,2,3; ctrl_out 10,11,12,13; err=0.
2. At upc=3: CJMP jump_addr=6 cond=0 -> upc 4 / ctrl_out 14. Then CJMP jump_addr=6 cond=1 -> upc 6 / ctrl_out 16. Then DISPATCH dispatch_addr=2 -> upc 2 / ctrl_out 12.
3. At upc=7: INC -> upc 0, ctrl_out 10, err=1. Then err_clr -> err=0. Then CJMP jump_addr=9 cond=1 -> upc 0, err=1.
4. At upc=4, same edge wr_en wr_addr=5 wr_data=AA and INC -> ctrl_out 15 (old word). Then FETCH, INC x5 -> upc 5 shows AA.
5. stall=1 for 3 cycles with seq_op=DISPATCH 7 -> upc and ctrl_out unchanged; stall=0 -> upc 7 / ctrl_out 17.
6. After the word-5 patch, assert reset -> word 5 reads 15 again; mid-sequence reset with wr_en=1 -> write discarded; upc 0, ctrl_out 10.
